// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the mult_share_arbiter slice: FSM state type,
// default sizing constants, channel indices and a one-hot decode helper.
// Optional feature macro used by the top: MULT_ARB_TIMEOUT_EN.
package mult_share_arbiter_pkg;

    // Default configuration
    localparam int unsigned NREQ_DEFAULT    = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 32;

    // Pointer is sized for the largest supported requester count (8)
    localparam int unsigned PTR_W = 3;
    typedef logic [PTR_W-1:0] ptr_t;

    // Channel order
    localparam int unsigned CH_RED   = 0;
    localparam int unsigned CH_GREEN = 1;
    localparam int unsigned CH_BLUE  = 2;
    localparam int unsigned CH_WHITE = 3;

    // FSM state encoding (binary)
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Index of the set bit of an (at most) 8-bit one-hot vector
    function automatic ptr_t oh_to_idx(input logic [7:0] oh);
        ptr_t idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | ptr_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// Round-robin winner selection: scans requests starting at the pointer,
// returns a one-hot winner and a valid flag. Purely combinational.
module rr_pick
    import mult_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT
) (
    input  logic [NREQ-1:0] req,
    input  ptr_t            ptr,
    output logic [NREQ-1:0] win,
    output logic            valid
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    int unsigned    idx;
    logic [IW-1:0]  sel;

    // First asserted request at or after the pointer, wrapping modulo NREQ
    always_comb begin
        win   = '0;
        valid = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = IW'(idx);
            if (!valid && req[sel]) begin
                win[sel] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Arbiter sharing one 8x8 multiplier among NREQ requesters, round-robin.
// FSM: IDLE -> LOAD (1 cycle, mult_ld) -> WAIT (until mult_rdy) -> DONE.
// Optional macro MULT_ARB_TIMEOUT_EN: abort WAIT after TIMEOUT_CYCLES with
// err=1 and res=0; without it err is tied low and no counter exists.
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ           = NREQ_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   op_a,
    input  logic [8*NREQ-1:0]   op_b,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [15:0]         res,
    output logic                err,
    output logic                mult_ld,
    output logic [7:0]          mult_a,
    output logic [7:0]          mult_b,
    input  logic                mult_rdy,
    input  logic [15:0]         mult_res
);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mult_share_arbiter: unsupported NREQ or TIMEOUT_CYCLES");
    end

    state_t             state_q, state_d;
    ptr_t               ptr_q, ptr_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [15:0]        res_q, res_d;
    logic               mult_ld_q, mult_ld_d;
    logic [7:0]         mult_a_q, mult_a_d;
    logic [7:0]         mult_b_q, mult_b_d;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    logic [NREQ-1:0]    pick_win;
    logic               pick_valid;
    logic [7:0]         sel_a, sel_b;
    logic [7:0]         gnt_pad;
    ptr_t               gnt_idx;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .win   (pick_win),
        .valid (pick_valid)
    );

    // Operand mux for the round-robin winner, and index of the served requester
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        gnt_pad = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_win[i]) begin
                sel_a = sel_a | op_a[8*i +: 8];
                sel_b = sel_b | op_b[8*i +: 8];
            end
        end
        gnt_pad[NREQ-1:0] = gnt_q;
        gnt_idx = oh_to_idx(gnt_pad);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        res_d     = res_q;
        mult_ld_d = 1'b0;
        mult_a_d  = mult_a_q;
        mult_b_d  = mult_b_q;
`ifdef MULT_ARB_TIMEOUT_EN
        err_d     = 1'b0;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (pick_valid) begin
                    gnt_d     = pick_win;
                    mult_a_d  = sel_a;
                    mult_b_d  = sel_b;
                    mult_ld_d = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
`ifdef MULT_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mult_rdy) begin
                    res_d   = mult_res;
                    done_d  = gnt_q;
                    state_d = ST_DONE;
`ifdef MULT_ARB_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            ST_DONE: begin
                ptr_d   = (gnt_idx == ptr_t'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            res_q     <= '0;
            mult_ld_q <= 1'b0;
            mult_a_q  <= '0;
            mult_b_q  <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            res_q     <= res_d;
            mult_ld_q <= mult_ld_d;
            mult_a_q  <= mult_a_d;
            mult_b_q  <= mult_b_d;
`ifdef MULT_ARB_TIMEOUT_EN
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign res     = res_q;
    assign mult_ld = mult_ld_q;
    assign mult_a  = mult_a_q;
    assign mult_b  = mult_b_q;
`ifdef MULT_ARB_TIMEOUT_EN
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: behavioural multiplier with
// configurable latency/stall, expected completions queued at stimulus time
// and compared on every done pulse.
module tb_mult_share_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int          LAT  = 8;
    localparam int          TMO  = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [8*NREQ-1:0]   op_a;
    logic [8*NREQ-1:0]   op_b;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [15:0]         res;
    logic                err;
    logic                mult_ld;
    logic [7:0]          mult_a;
    logic [7:0]          mult_b;
    logic                mult_rdy;
    logic [15:0]         mult_res;

    always #5 clk = ~clk;

    mult_share_arbiter #(
        .NREQ           (NREQ),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .op_a     (op_a),
        .op_b     (op_b),
        .gnt      (gnt),
        .done     (done),
        .res      (res),
        .err      (err),
        .mult_ld  (mult_ld),
        .mult_a   (mult_a),
        .mult_b   (mult_b),
        .mult_rdy (mult_rdy),
        .mult_res (mult_res)
    );

    typedef struct {
        logic [NREQ-1:0] mask;
        logic [15:0]     res;
        logic            err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ndone = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;
    int ld_cnt = 0;
    logic stall = 1'b0;

    logic        m_busy;
    int          m_cnt;
    logic [15:0] m_prod;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Shared multiplier model: product ready LAT cycles after the load strobe
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_cnt    <= 0;
            m_prod   <= '0;
            mult_rdy <= 1'b0;
            mult_res <= 16'hDEAD;
        end else begin
            mult_rdy <= 1'b0;
            mult_res <= 16'hDEAD;
            if (mult_ld) begin
                m_busy <= 1'b1;
                m_cnt  <= LAT;
                m_prod <= mult_a * mult_b;
            end else if (m_busy && !stall) begin
                if (m_cnt <= 1) begin
                    mult_rdy <= 1'b1;
                    mult_res <= m_prod;
                    m_busy   <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // Count load strobe cycles
    always @(negedge clk) if (mult_ld) ld_cnt++;

    // Scoreboard compare on each completion pulse
    always @(negedge clk) begin
        if (rst_n && (done != '0)) begin
            check("done_onehot", 32'($onehot(done)), 32'd1);
            check("gnt_eq_done", 32'(gnt), 32'(done));
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("done_idx", 32'(done), 32'(mon_e.mask));
                check("res", 32'(res), 32'(mon_e.res));
                check("err", 32'(err), 32'(mon_e.err));
            end
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            ndone++;
        end
    end

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        op_a[8*i +: 8] = a;
        op_b[8*i +: 8] = b;
    endtask

    task automatic push(input int i, input logic [15:0] r, input logic e);
        exp_t x;
        x.mask    = '0;
        x.mask[i] = 1'b1;
        x.res     = r;
        x.err     = e;
        sb.push_back(x);
    endtask

    task automatic wait_dones(input int target, input int budget);
        int k;
        k = 0;
        while (ndone < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("done_count", 32'(ndone), 32'(target));
    endtask

    task automatic check_rst_outputs();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mult_ld", 32'(mult_ld), 32'd0);
        check("rst_mult_a", 32'(mult_a), 32'd0);
        check("rst_mult_b", 32'(mult_b), 32'd0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        int n0;
        rst_n = 1'b0;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(negedge clk);
        #1;
        check_rst_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Single request, 200*3, latency and single load strobe
        set_op(0, 8'd200, 8'd3);
        push(0, 16'd600, 1'b0);
        ld_cnt = 0;
        t0 = cyc;
        req = 4'b0001;
        wait_dones(1, 40);
        check("mult_a_hold", 32'(mult_a), 32'd200);
        check("mult_b_hold", 32'(mult_b), 32'd3);
        req = '0;
        check("single_latency", 32'(last_done_cyc - t0), 32'(LAT + 3));
        check("mult_ld_pulses", 32'(ld_cnt), 32'd1);
        @(negedge clk);
        #1;

        // Reset while requester 1 is in WAIT; served again after release
        set_op(1, 8'd17, 8'd9);
        req = 4'b0010;
        repeat (5) @(negedge clk);
        #1;
        check("pre_rst_gnt", 32'(gnt), 32'b0010);
        rst_n = 1'b0;
        #1;
        check_rst_outputs();
        n0 = ndone;
        repeat (3) @(negedge clk);
        #1;
        check("rst_no_done", 32'(ndone), 32'(n0));
        push(1, 16'd153, 1'b0);
        rst_n = 1'b1;
        wait_dones(n0 + 1, 40);
        req = '0;

        // Pointer now 2: req=0101 serves 2 then 0; boundary operands
        set_op(2, 8'h00, 8'hAB);
        set_op(0, 8'hFF, 8'hFF);
        push(2, 16'h0000, 1'b0);
        push(0, 16'hFE01, 1'b0);
        n0 = ndone;
        req = 4'b0101;
        wait_dones(n0 + 1, 40);
        req[2] = 1'b0;
        wait_dones(n0 + 2, 40);
        req = '0;

        // Requester 3 alone moves the pointer back to 0
        set_op(3, 8'd12, 8'd11);
        push(3, 16'd132, 1'b0);
        n0 = ndone;
        req = 4'b1000;
        wait_dones(n0 + 1, 40);
        req = '0;

        // All requesters held: order 0,1,2,3,0
        set_op(0, 8'd7, 8'd9);
        set_op(1, 8'd255, 8'd2);
        set_op(2, 8'd100, 8'd100);
        set_op(3, 8'd13, 8'd1);
        push(0, 16'd63, 1'b0);
        push(1, 16'd510, 1'b0);
        push(2, 16'd10000, 1'b0);
        push(3, 16'd13, 1'b0);
        push(0, 16'd63, 1'b0);
        n0 = ndone;
        req = 4'b1111;
        wait_dones(n0 + 5, 100);
        req = '0;

        // Single requester held: back-to-back with one IDLE cycle
        set_op(1, 8'd33, 8'd3);
        push(1, 16'd99, 1'b0);
        push(1, 16'd99, 1'b0);
        n0 = ndone;
        req = 4'b0010;
        wait_dones(n0 + 2, 50);
        req = '0;
        check("b2b_gap", 32'(last_done_cyc - prev_done_cyc), 32'(LAT + 4));

        // Multiplier never ready
        set_op(0, 8'd5, 8'd7);
        stall = 1'b1;
        n0 = ndone;
`ifdef MULT_ARB_TIMEOUT_EN
        push(0, 16'd0, 1'b1);
        t0 = cyc;
        req = 4'b0001;
        wait_dones(n0 + 1, 60);
        req = '0;
        check("timeout_latency", 32'(last_done_cyc - t0), 32'(TMO + 2));
        stall = 1'b0;
`else
        req = 4'b0001;
        repeat (60) @(negedge clk);
        #1;
        check("stall_no_done", 32'(ndone), 32'(n0));
        push(0, 16'd35, 1'b0);
        stall = 1'b0;
        wait_dones(n0 + 1, 30);
        req = '0;
`endif

        repeat (3) @(negedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
